// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer slice.
// Provides default geometry (depth, address/data widths), the pointer width
// and the packed entry record {addr, data, pc} held in each buffer slot.
package sb_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_AW    = 12;
    localparam int unsigned SB_DW    = 32;
    localparam int unsigned SB_PW    = $clog2(SB_DEPTH);

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
        logic [SB_DW-1:0] pc;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// M-stage <-> store buffer port bundle.
//   st_valid/st_addr/st_data/st_pc : store presented by M stage
//   st_ready                       : buffer can accept a store (!full)
//   ld_valid/ld_addr               : M-stage load (DM port busy)
//   fwd_hit/fwd_data               : youngest buffered match for ld_addr
// master = M stage, slave = store buffer.
interface store_buffer_if
    import sb_pkg::*;
#(
    parameter int unsigned AW = SB_AW,
    parameter int unsigned DW = SB_DW
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [DW-1:0] st_pc;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    modport master (
        output st_valid, st_addr, st_data, st_pc, ld_valid, ld_addr,
        input  st_ready, fwd_hit, fwd_data
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_pc, ld_valid, ld_addr,
        output st_ready, fwd_hit, fwd_data
    );
endinterface

// File: rtl/store_buffer_fwd_match.sv
// sb_fwd_match: combinational youngest-match search for load forwarding.
// Walks from tail-1 back toward head; the first valid entry whose address
// equals ld_addr wins.
//   valid   : per-slot occupancy mask
//   addrs   : per-slot word addresses
//   datas   : per-slot store data
//   head    : oldest slot, tail : next free slot
//   ld_addr : load word address
//   hit     : a match was found
//   data    : matching data, 0 when no hit
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         valid,
    input  logic [DEPTH-1:0][AW-1:0] addrs,
    input  logic [DEPTH-1:0][DW-1:0] datas,
    input  logic [PW-1:0]            head,
    input  logic [PW-1:0]            tail,
    input  logic [AW-1:0]            ld_addr,
    output logic                     hit,
    output logic [DW-1:0]            data
);

    logic [PW-1:0] idx;
    logic          done;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        done = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail - PW'(k + 1);
            if (!done && valid[idx] && (addrs[idx] == ld_addr)) begin
                hit  = 1'b1;
                data = datas[idx];
                done = 1'b1;
            end
            // Head is the oldest slot; nothing older to search.
            if (idx == head) begin
                done = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of pending word stores between M-stage memory
// logic and the DM write port. Retires the oldest store whenever no load
// needs DM's shared address port, and forwards buffered data to loads.
// Ports:
//   clk, reset (synchronous, active low)
//   m_port  : store_buffer_if.slave (store push, load forward)
//   dm_we/dm_wa/dm_wd/dm_pc : DM write port plus originating PC for trace
//   count/empty/full        : occupancy status
// Entry storage uses sb_pkg::sb_entry_t, sized by the package AW/DW.
// Optional: STORE_BUF_COALESCE_EN merges a store into the youngest entry when
// addresses match (in place, accepted even when full).
module store_buffer
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW
) (
    input  logic                   clk,
    input  logic                   reset,
    store_buffer_if.slave          m_port,
    output logic                   dm_we,
    output logic [AW-1:0]          dm_wa,
    output logic [DW-1:0]          dm_wd,
    output logic [DW-1:0]          dm_pc,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t     mem [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          push, drain;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    // Deliberately ignores a same-cycle drain to keep st_ready off that path.
    assign m_port.st_ready = !full;

    // Gated by reset so no write escapes in a reset cycle.
    assign drain = reset && !empty && !m_port.ld_valid;

`ifdef STORE_BUF_COALESCE_EN
    logic [PW-1:0] young;
    logic          coal;

    assign young = tail_q - PW'(1);
    // Youngest entry that is also the draining head must not absorb the store.
    assign coal  = m_port.st_valid && !empty && (mem[young].addr == m_port.st_addr)
                   && !((count_q == CW'(1)) && drain);
    assign push  = m_port.st_valid && !full && !coal;
`else
    assign push  = m_port.st_valid && !full;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= '{addr: m_port.st_addr, data: m_port.st_data, pc: m_port.st_pc};
        end
`ifdef STORE_BUF_COALESCE_EN
        if (coal) begin
            mem[young].data <= m_port.st_data;
            mem[young].pc   <= m_port.st_pc;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (drain) begin
                head_q <= head_q + PW'(1);
            end
            case ({push, drain})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        dm_we = drain;
        dm_wa = '0;
        dm_wd = '0;
        dm_pc = '0;
        if (!empty) begin
            dm_wa = mem[head_q].addr;
            dm_wd = mem[head_q].data;
            dm_pc = mem[head_q].pc;
        end
    end

    // Occupancy mask and flattened views for the forwarding search.
    logic [DEPTH-1:0]         valid;
    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic [PW-1:0]            off;

    always_comb begin
        valid    = '0;
        ent_addr = '0;
        ent_data = '0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off         = PW'(i) - head_q;
            valid[i]    = ({1'b0, off} < count_q);
            ent_addr[i] = mem[i].addr;
            ent_data[i] = mem[i].data;
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd (
        .valid   (valid),
        .addrs   (ent_addr),
        .datas   (ent_data),
        .head    (head_q),
        .tail    (tail_q),
        .ld_addr (m_port.ld_addr),
        .hit     (m_port.fwd_hit),
        .data    (m_port.fwd_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed stimulus; every expected DM write is queued
// when issued and a negedge monitor pops and compares each dm_we cycle.
module tb_store_buffer;
    import sb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        dm_we;
    logic [11:0] dm_wa;
    logic [31:0] dm_wd, dm_pc;
    logic [2:0]  count;
    logic        empty, full;

    always #5 clk = ~clk;

    store_buffer_if #(.AW(12), .DW(32)) bus ();

    store_buffer #(.DEPTH(4), .AW(12), .DW(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .m_port (bus),
        .dm_we  (dm_we),
        .dm_wa  (dm_wa),
        .dm_wd  (dm_wd),
        .dm_pc  (dm_pc),
        .count  (count),
        .empty  (empty),
        .full   (full)
    );

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   nvec  = 0;
    int   nfail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic v, input logic [11:0] a, input logic [31:0] d,
                      input logic [31:0] p);
        bus.st_valid = v;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.st_pc    = p;
    endtask

    task automatic expect_wr(input logic [11:0] a, input logic [31:0] d, input logic [31:0] p);
        exp_q.push_back('{a: a, d: d, p: p});
    endtask

    // Scoreboard monitor: every DM write must match the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (dm_we === 1'b1) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nfail++;
                $display("FAIL dm_write: got wa=0x%0h wd=0x%0h pc=0x%0h, want no write",
                         dm_wa, dm_wd, dm_pc);
            end else begin
                e = exp_q.pop_front();
                if ({dm_wa, dm_wd, dm_pc} !== {e.a, e.d, e.p}) begin
                    nfail++;
                    $display("FAIL dm_write: got wa=0x%0h wd=0x%0h pc=0x%0h, want wa=0x%0h wd=0x%0h pc=0x%0h",
                             dm_wa, dm_wd, dm_pc, e.a, e.d, e.p);
                end
            end
        end
    end

    initial begin
        reset        = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        st(1'b0, 12'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_st_ready", bus.st_ready, 1);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_count", count, 0);
        chk("rst_fwd_hit", bus.fwd_hit, 0);
        chk("rst_fwd_data", bus.fwd_data, 0);

        // Single store drains the following cycle.
        tick();
        st(1'b1, 12'h010, 32'hDEADBEEF, 32'h3000);
        expect_wr(12'h010, 32'hDEADBEEF, 32'h3000);
        tick();
        st(1'b0, 12'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t1_dm_we", dm_we, 1);
        tick();
        @(negedge clk);
        chk("t1_empty_after", empty, 1);

        // Fill while loads block DM, then drop a 5th store.
        tick();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 12'h3FF;
        for (int i = 0; i < 4; i++) begin
            st(1'b1, 12'h100 + 12'(i), 32'hA0 + 32'(i), 32'h4000 + 32'(4 * i));
            expect_wr(12'h100 + 12'(i), 32'hA0 + 32'(i), 32'h4000 + 32'(4 * i));
            tick();
        end
        st(1'b1, 12'h1FF, 32'hBAD, 32'h4FFF);
        @(negedge clk);
        chk("t2_full", full, 1);
        chk("t2_st_ready", bus.st_ready, 0);
        chk("t2_count_full", count, 4);
        tick();
        st(1'b0, 12'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t2_count_after_drop", count, 4);
        bus.ld_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("t2_empty_after_drain", empty, 1);

        // Forwarding: youngest match wins; a same-cycle push is invisible.
        tick();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 12'h020;
        st(1'b1, 12'h020, 32'h1, 32'h5000);
        tick();
        st(1'b1, 12'h020, 32'h2, 32'h5004);
        tick();
        st(1'b1, 12'h030, 32'h3, 32'h5008);
        bus.ld_addr = 12'h030;
        @(negedge clk);
        chk("t3_same_cycle_hidden", bus.fwd_hit, 0);
        tick();
        st(1'b0, 12'h0, 32'h0, 32'h0);
        bus.ld_addr = 12'h020;
        @(negedge clk);
        chk("t3_hit_020", bus.fwd_hit, 1);
        chk("t3_data_020", bus.fwd_data, 2);
`ifdef STORE_BUF_COALESCE_EN
        chk("t3_count_coalesced", count, 2);
`else
        chk("t3_count", count, 3);
`endif
        tick();
        bus.ld_addr = 12'h021;
        @(negedge clk);
        chk("t3_miss_hit", bus.fwd_hit, 0);
        chk("t3_miss_data", bus.fwd_data, 0);
        tick();
        bus.ld_addr = 12'h030;
        @(negedge clk);
        chk("t3_data_030", bus.fwd_data, 3);
`ifndef STORE_BUF_COALESCE_EN
        expect_wr(12'h020, 32'h1, 32'h5000);
`endif
        expect_wr(12'h020, 32'h2, 32'h5004);
        expect_wr(12'h030, 32'h3, 32'h5008);
        tick();
        bus.ld_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("t3_empty_after_drain", empty, 1);

        // Steady state at count 3: push and drain every cycle, pointers wrap.
        tick();
        bus.ld_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            st(1'b1, 12'h200 + 12'(k), 32'hC000 + 32'(k), 32'h6000 + 32'(4 * k));
            expect_wr(12'h200 + 12'(k), 32'hC000 + 32'(k), 32'h6000 + 32'(4 * k));
            tick();
        end
        bus.ld_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            st(1'b1, 12'h210 + 12'(k), 32'hD000 + 32'(k), 32'h7000 + 32'(4 * k));
            expect_wr(12'h210 + 12'(k), 32'hD000 + 32'(k), 32'h7000 + 32'(4 * k));
            @(negedge clk);
            chk("t4_count_steady", count, 3);
            tick();
        end
        st(1'b0, 12'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t4_count_after_loop", count, 3);
        repeat (3) tick();
        @(negedge clk);
        chk("t4_empty_after_drain", empty, 1);

        // Reset mid-operation discards pending stores without writing DM.
        tick();
        bus.ld_valid = 1'b1;
        st(1'b1, 12'h300, 32'hE000, 32'h8000);
        tick();
        st(1'b1, 12'h301, 32'hE001, 32'h8004);
        tick();
        st(1'b0, 12'h0, 32'h0, 32'h0);
        bus.ld_valid = 1'b0;
        reset        = 1'b0;
        @(negedge clk);
        chk("t5_dm_we_in_reset", dm_we, 0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_count_after_reset", count, 0);
        chk("t5_empty_after_reset", empty, 1);

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
